// File: rtl/spi_reg_pkg.sv
// Purpose: shared constants for the SPI register controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package spi_reg_pkg;

  localparam int BYTE_W     = 8;
  localparam int CMD_RW_BIT = 7;   // command byte bit 7: 1 = read, 0 = write

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CMD  = 2'd1;
  localparam state_t DATA = 2'd2;

endpackage

// File: rtl/spi_pin_sync.sv
// Purpose: synchronise SPI pins into clk and produce single-clk edge events.
// Latency: SYNC_STAGES+1 clk from pin change to event-driven action.
// Backpressure: none; events are single-clk pulses that must be consumed.
//
// Ports:
//   clk, rst_n     system clock / async active-low reset
//   sck, ssel,mosi raw SPI pins
//   sck_rise/fall  synced SCK edge pulses
//   ssel_start/end synced SSEL falling / rising edge pulses
//   ssel_active    synced SSEL is low
//   mosi_s         synced MOSI, aligned with the sck edge pulses
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  input  logic ssel,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic ssel_start,
  output logic ssel_end,
  output logic ssel_active,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] ssel_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sck_h;
  logic                   ssel_h;

  // SSEL chain resets to the deasserted level so reset never looks like a select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q  <= '0;
      ssel_q <= '1;
      mosi_q <= '0;
      sck_h  <= 1'b0;
      ssel_h <= 1'b1;
    end else begin
      sck_q  <= {sck_q[SYNC_STAGES-2:0], sck};
      ssel_q <= {ssel_q[SYNC_STAGES-2:0], ssel};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sck_h  <= sck_q[SYNC_STAGES-1];
      ssel_h <= ssel_q[SYNC_STAGES-1];
    end
  end

  // MOSI travels through the same depth as SCK, so mosi_s is the bit that
  // was on the pin when SCK rose.
  assign sck_rise    =  sck_q[SYNC_STAGES-1] & ~sck_h;
  assign sck_fall    = ~sck_q[SYNC_STAGES-1] &  sck_h;
  assign ssel_start  = ~ssel_q[SYNC_STAGES-1] &  ssel_h;
  assign ssel_end    =  ssel_q[SYNC_STAGES-1] & ~ssel_h;
  assign ssel_active = ~ssel_q[SYNC_STAGES-1];
  assign mosi_s      =  mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_reg_ctrl.sv
// Purpose: SPI mode-0 slave giving a host read/write access to 2**ADDR_W 8-bit registers.
// Latency: SYNC_STAGES+1 clk from SCK pin edge to shift/commit; wr_stb with regs_out update.
// Backpressure: none; the SPI master paces everything, f_SCK must be <= f_clk/8.
//
// Ports:
//   clk, rst_n   system clock / async active-low reset
//   SSEL,SCK,MOSI,MISO  SPI slave pins (select active low, SCK idle low)
//   status_in    byte shifted out during the command byte
//   regs_out     register bank, reg i at [8i+7:8i]
//   wr_stb/wr_addr/wr_data  one-clk pulse per committed register write
//   busy         transaction in progress
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         SSEL,
  input  logic                         SCK,
  input  logic                         MOSI,
  output logic                         MISO,
  input  logic [7:0]                   status_in,
  output logic [8*(2**ADDR_W)-1:0]     regs_out,
  output logic                         wr_stb,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [7:0]                   wr_data,
  output logic                         busy
);

  logic sck_rise, sck_fall, ssel_start, ssel_end, ssel_active, mosi_s;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .sck         (SCK),
    .ssel        (SSEL),
    .mosi        (MOSI),
    .sck_rise    (sck_rise),
    .sck_fall    (sck_fall),
    .ssel_start  (ssel_start),
    .ssel_end    (ssel_end),
    .ssel_active (ssel_active),
    .mosi_s      (mosi_s)
  );

  state_t              state;
  logic [2:0]          bit_cnt;
  logic [6:0]          rx_shift;
  logic [6:0]          tx_shift;   // bits still to go out after the one on MISO
  logic [7:0]          tx_next;
  logic                byte_done;  // a byte completed since the last SCK fall
  logic                rw;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]   ptr_inc;
  logic [7:0]          rx_byte;
  logic                sck_ok;

  assign rx_byte = {rx_shift, mosi_s};
  assign ptr_inc = ptr + 1'b1;
  assign busy    = (state != IDLE);
  // ssel_end keeps a byte that finishes on the deselecting clk
  assign sck_ok  = ssel_active | ssel_end;

  function automatic logic [7:0] reg_rd(input logic [ADDR_W-1:0] a);
    return regs_out[a*BYTE_W +: BYTE_W];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      rx_shift  <= 7'd0;
      tx_shift  <= 7'd0;
      tx_next   <= 8'h00;
      byte_done <= 1'b0;
      rw        <= 1'b0;
      ptr       <= '0;
      MISO      <= 1'b0;
      regs_out  <= '0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'h00;
    end else begin
      wr_stb <= 1'b0;
      if (state == IDLE) begin
        if (ssel_start) begin
          state     <= CMD;
          bit_cnt   <= 3'd0;
          tx_shift  <= status_in[6:0];
          MISO      <= status_in[7];
          byte_done <= 1'b0;
        end
      end else begin
        if (sck_rise && sck_ok) begin
          rx_shift <= rx_byte[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_done <= 1'b1;
            if (state == CMD) begin
              rw      <= rx_byte[CMD_RW_BIT];
              ptr     <= rx_byte[ADDR_W-1:0];
              tx_next <= rx_byte[CMD_RW_BIT] ? reg_rd(rx_byte[ADDR_W-1:0]) : 8'h00;
              state   <= DATA;
            end else if (rw) begin
              ptr     <= ptr_inc;
              tx_next <= reg_rd(ptr_inc);
            end else begin
              regs_out[ptr*BYTE_W +: BYTE_W] <= rx_byte;
              wr_stb  <= 1'b1;
              wr_addr <= ptr;
              wr_data <= rx_byte;
              ptr     <= ptr_inc;
              tx_next <= 8'h00;
            end
          end
        end
        if (sck_fall && sck_ok) begin
          if (byte_done) begin
            MISO      <= tx_next[7];
            tx_shift  <= tx_next[6:0];
            byte_done <= 1'b0;
          end else begin
            MISO      <= tx_shift[6];
            tx_shift  <= {tx_shift[5:0], 1'b0};
          end
        end
        if (ssel_end) begin
          state   <= IDLE;
          MISO    <= 1'b0;
          bit_cnt <= 3'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
module tb_spi_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SSEL = 1'b1;
  logic        SCK = 1'b0;
  logic        MOSI = 1'b0;
  logic [7:0]  status_in = 8'h5A;
  logic        MISO;
  logic [63:0] regs_out;
  logic        wr_stb;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int half   = 6;
  int wr_cnt = 0;
  int base   = 0;
  logic [2:0] log_addr[$];
  logic [7:0] log_data[$];
  logic [7:0] rx;

  spi_reg_ctrl #(.ADDR_W(3), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SSEL      (SSEL),
    .SCK       (SCK),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .status_in (status_in),
    .regs_out  (regs_out),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // wr_stb is one clk wide, so each pulse is seen at exactly one falling edge
  always @(negedge clk) begin
    if (wr_stb) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      wr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ssel_lo();
    SSEL = 1'b0;
    tick(2 * half);
  endtask

  task automatic ssel_hi();
    tick(half);
    SSEL = 1'b1;
    tick(2 * half);
  endtask

  // send the top n bits of tx; MISO is sampled just before each rising SCK
  task automatic bits(input int n, input logic [7:0] tx, output logic [7:0] got);
    got = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      MOSI = tx[i];
      tick(half);
      got[i] = MISO;
      SCK = 1'b1;
      tick(half);
      SCK = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] got);
    bits(8, tx, got);
  endtask

  initial begin
    int k;
    logic [7:0] d;

    // reset state
    tick(3);
    chk("rst_regs",    regs_out,        64'h0);
    chk("rst_miso",    64'(MISO),       64'h0);
    chk("rst_busy",    64'(busy),       64'h0);
    chk("rst_wr_stb",  64'(wr_stb),     64'h0);
    chk("rst_wr_addr", 64'(wr_addr),    64'h0);
    chk("rst_wr_data", 64'(wr_data),    64'h0);
    rst_n = 1'b1;
    tick(3);

    // reset in the middle of a transaction
    ssel_lo();
    xfer(8'h00, rx);
    xfer(8'h55, rx);
    chk("pre_rst_reg0", 64'(regs_out[7:0]), 64'h55);
    bits(3, 8'hFF, rx);
    chk("pre_rst_busy", 64'(busy), 64'h1);
    rst_n = 1'b0;
    tick(1);
    chk("midrst_regs", regs_out,   64'h0);
    chk("midrst_miso", 64'(MISO),  64'h0);
    chk("midrst_busy", 64'(busy),  64'h0);
    chk("midrst_stb",  64'(wr_stb), 64'h0);
    SSEL = 1'b1;
    SCK  = 1'b0;
    tick(4);
    rst_n = 1'b1;
    tick(6);
    chk("postrst_busy", 64'(busy), 64'h0);

    // write two bytes starting at reg2
    base = wr_cnt;
    ssel_lo();
    xfer(8'h02, rx);
    chk("w2_cmd_miso", 64'(rx), 64'h5A);
    chk("w2_busy", 64'(busy), 64'h1);
    xfer(8'h11, rx);
    chk("w2_d0_miso", 64'(rx), 64'h00);
    xfer(8'h22, rx);
    ssel_hi();
    chk("w2_regs",  regs_out, 64'h0000_0000_2211_0000);
    chk("w2_count", 64'(wr_cnt - base), 64'd2);
    chk("w2_a0", 64'(log_addr[base]),     64'd2);
    chk("w2_d0", 64'(log_data[base]),     64'h11);
    chk("w2_a1", 64'(log_addr[base + 1]), 64'd3);
    chk("w2_d1", 64'(log_data[base + 1]), 64'h22);
    chk("w2_idle", 64'(busy), 64'h0);

    // preload reg7 / reg0 for the read test
    ssel_lo();
    xfer(8'h07, rx);
    xfer(8'hA7, rx);
    xfer(8'hB0, rx);
    ssel_hi();
    chk("pre_regs", regs_out, 64'hA700_0000_2211_00B0);

    // burst read with wrap 7 -> 0
    status_in = 8'hC3;
    base = wr_cnt;
    ssel_lo();
    xfer(8'h87, rx);
    chk("rd_status", 64'(rx), 64'hC3);
    xfer(8'h00, rx);
    chk("rd_reg7", 64'(rx), 64'hA7);
    xfer(8'h00, rx);
    chk("rd_reg0", 64'(rx), 64'hB0);
    ssel_hi();
    chk("rd_no_stb", 64'(wr_cnt - base), 64'd0);
    chk("rd_regs",   regs_out, 64'hA700_0000_2211_00B0);

    // write with wrap 7 -> 0
    status_in = 8'h5A;
    base = wr_cnt;
    ssel_lo();
    xfer(8'h07, rx);
    xfer(8'hC1, rx);
    xfer(8'hC2, rx);
    ssel_hi();
    chk("ww_regs",  regs_out, 64'hC100_0000_2211_00C2);
    chk("ww_count", 64'(wr_cnt - base), 64'd2);
    chk("ww_a0", 64'(log_addr[base]),     64'd7);
    chk("ww_a1", 64'(log_addr[base + 1]), 64'd0);

    // abort after a partial data byte
    base = wr_cnt;
    ssel_lo();
    xfer(8'h01, rx);
    bits(5, 8'hFF, rx);
    tick(half);
    chk("ab_busy_before", 64'(busy), 64'h1);
    SSEL = 1'b1;
    k = 0;
    while (busy && k < 4) begin
      tick(1);
      k++;
    end
    chk("ab_busy_fall", 64'(busy), 64'h0);
    tick(2 * half);
    chk("ab_regs",   regs_out, 64'hC100_0000_2211_00C2);
    chk("ab_no_stb", 64'(wr_cnt - base), 64'd0);
    chk("ab_miso",   64'(MISO), 64'h0);

    // SCK activity while deselected
    base = wr_cnt;
    MOSI = 1'b1;
    repeat (10) begin
      SCK = 1'b1;
      tick(half);
      SCK = 1'b0;
      tick(half);
    end
    chk("idle_busy",   64'(busy), 64'h0);
    chk("idle_miso",   64'(MISO), 64'h0);
    chk("idle_no_stb", 64'(wr_cnt - base), 64'd0);
    chk("idle_regs",   regs_out, 64'hC100_0000_2211_00C2);

    // f_SCK = f_clk/8: 16-byte write from reg3, wraps twice
    half = 4;
    base = wr_cnt;
    ssel_lo();
    xfer(8'h03, rx);
    chk("st_cmd_miso", 64'(rx), 64'h5A);
    for (int i = 0; i < 16; i++) begin
      d = 8'hE0 + 8'(i);
      xfer(d, rx);
    end
    ssel_hi();
    chk("st_regs",  regs_out, 64'hECEB_EAE9_E8EF_EEED);
    chk("st_count", 64'(wr_cnt - base), 64'd16);
    chk("st_first_a", 64'(log_addr[base]),      64'd3);
    chk("st_first_d", 64'(log_data[base]),      64'hE0);
    chk("st_last_a",  64'(log_addr[base + 15]), 64'd2);
    chk("st_last_d",  64'(log_data[base + 15]), 64'hEF);
    chk("st_idle",    64'(busy), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- SPI slave controller (mode 0, MSB first, 8-bit frames) that sequences an SCK-oversampled shift datapath into a small register bank.
- Each SSEL-low transaction is one command byte followed by 0..N data bytes; the address auto-increments.
- Sits between the MCU SPI pins and the FPGA application logic. Exposes register contents, a write strobe and a status byte readback.

Parameters:
- ADDR_W, 3, register address width; NREGS = 2**ADDR_W registers of 8 bits.
- SYNC_STAGES, 2, synchronizer flops on SCK/SSEL/MOSI (minimum 2).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- SSEL  in  1  SPI chip select, active low.
- SCK  in  1  SPI clock, idle low.
- MOSI  in  1  SPI data in.
- MISO  out  1  SPI data out.
- status_in  in  8  status byte returned during the command byte.
- regs_out  out  8*NREGS  register bank, reg i at bits [8i+7:8i].
- wr_stb  out  1  one-clk pulse per committed register write.
- wr_addr  out  ADDR_W  address of the committed write (valid with wr_stb).
- wr_data  out  8  data of the committed write (valid with wr_stb).
- busy  out  1  high while a transaction is in progress (state != IDLE).

Behaviour:
- Reset (async, rst_n=0): MISO=0, all regs_out=0, wr_stb=0, wr_addr=0, wr_data=0, busy=0, state=IDLE, bit_cnt=0, sync flops=0 (SSEL sync flops=1).
- Sync: SCK, SSEL and MOSI each pass through SYNC_STAGES flops plus one history flop.
  - sck_rise = hist 01, sck_fall = hist 10.
  - ssel_start = synced SSEL 1->0; ssel_end = synced SSEL 0->1.
  - Pin-to-action latency is SYNC_STAGES+1 clk. Guaranteed operation requires f_SCK <= f_clk/8.
- States: IDLE, CMD, DATA.
- IDLE:
  - on ssel_start: -> CMD, bit_cnt=0, tx_shift=status_in, MISO=status_in[7].
  - SCK edges are ignored while in IDLE.
- Rising SCK (CMD/DATA): rx_shift = {rx_shift[6:0], MOSI_sync}; bit_cnt++ (3-bit, wraps 7->0).
- Byte complete = rising edge with bit_cnt==7. The byte value is {rx_shift[6:0], MOSI_sync}.
- Falling SCK (CMD/DATA):
  - if a byte completed since the last fall: tx_shift=tx_next, MISO=tx_next[7];
  - else: tx_shift <<= 1, MISO=tx_shift[6].
- CMD byte complete:
  - rw = byte[7] (1=read); ptr = byte[ADDR_W-1:0]; remaining bits ignored.
  - if read: tx_next = reg[ptr]; if write: tx_next = 0x00.
  - -> DATA.
- DATA byte complete, write:
  - reg[ptr] = byte; wr_stb=1 for exactly 1 clk with wr_addr=ptr, wr_data=byte;
  - ptr = ptr+1 mod NREGS; tx_next = 0x00.
- DATA byte complete, read:
  - ptr = ptr+1 mod NREGS; tx_next = reg[new ptr]. The first read byte was preloaded at CMD completion.
- Register values change only on a committed write; regs_out is updated the same clk as wr_stb.
- ssel_end in any state:
  - -> IDLE the next clk, MISO=0, bit_cnt=0.
  - A partial byte is discarded with no write. A completed byte on the same clk as ssel_end is still committed.
- ssel_start while not IDLE (glitch, SSEL high shorter than the sync window) is not detectable; behaviour is the same as a continued transaction.
- Wrap-around: ptr NREGS-1 -> 0 for both reads and writes.
- A reset mid-transaction immediately returns all state to reset values. The remainder of that SPI frame is ignored until the next ssel_start.
- busy = (state != IDLE).

Decomposition:
- Package spi_reg_pkg: state enum (IDLE, CMD, DATA), CMD_RW_BIT=7, BYTE_W=8.
- Sub-module spi_pin_sync: synchronizer and edge detect for SCK/SSEL/MOSI.
  - Outputs: sck_rise, sck_fall, ssel_start, ssel_end, ssel_active, mosi_s.
- spi_reg_ctrl holds the FSM, shift registers, pointer and register bank.

Test Plan:
- Reset: rst_n=0 mid-transaction, then 1 -> regs_out all 0x00, MISO=0, busy=0, no wr_stb.
- Write 2 bytes: SSEL low; send 0x02, 0x11, 0x22; SSEL high.
  - Expected: reg2=0x11, reg3=0x22; exactly 2 wr_stb pulses (addr 2 then 3); MISO byte during CMD = status_in (0x5A).
- Burst read with wrap: preload reg7=0xA7, reg0=0xB0; send 0x87, 0x00, 0x00.
  - Expected: MISO bytes = status_in, 0xA7, 0xB0; no wr_stb.
- Wrap on write: send 0x07, 0xC1, 0xC2 -> reg7=0xC1, reg0=0xC2.
- Abort: send 0x01, then 5 bits of 0xFF, then SSEL high -> reg1 unchanged, no wr_stb, busy falls within SYNC_STAGES+2 clk.
- SCK edges with SSEL high, then f_SCK = f_clk/8 stress: 16-byte write with address wrap.
  - Expected: SCK edges while idle cause no state change; all 8 registers hold the last-written values; 16 wr_stb pulses.
